// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_controller
// Description : Pipeline sequencing controller for the 5-stage RISC-V core.
//               Detects load-use hazards against the IF/ID instruction,
//               squashes wrong-path instructions after a taken branch and
//               freezes the pipe while data memory is busy.
//
//               Ports
//                 clk, reset     : core clock, asynchronous active-high reset
//                 if_id_opcode   : opcode of the instruction in IF/ID
//                 if_id_rs1/rs2  : source register fields in IF/ID
//                 id_ex_rd       : destination register in ID/EX
//                 id_ex_memread  : MemRead of the instruction in ID/EX
//                 branch_taken   : Branch AND Zero, resolved in MEM
//                 mem_busy       : data memory not ready
//                 pc_write       : PC load enable
//                 if_id_write    : IF/ID load enable
//                 if_id_flush    : clear IF/ID to NOP
//                 id_ex_bubble   : select zeroed control bundle into ID/EX
//                 ex_mem_flush   : clear EX/MEM control bits
//                 pipe_hold      : hold ID/EX, EX/MEM, MEM/WB
//                 stall_cnt      : load-use stall cycles
//                 flush_cnt      : accepted taken-branch flushes
//
//               Build option HAZARD_PERF_CNT_EN: when defined, stall_cnt and
//               flush_cnt are saturating counters; otherwise both are tied
//               to zero and no counter flops exist.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int REDIRECT_LAT = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       if_id_opcode,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // State encoding
    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_flush  = 2'd1;
    localparam logic [1:0] c_st_freeze = 2'd2;

    // Opcodes that read rs1 / rs2
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;

    // Redirect latency clamped into the 3-bit counter's legal range 1..7
    localparam int         c_lat_clamped = (REDIRECT_LAT < 1) ? 1 :
                                           (REDIRECT_LAT > 7) ? 7 : REDIRECT_LAT;
    localparam logic [2:0] c_redirect_init = 3'(c_lat_clamped);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [2:0] r_redirect_cnt;
    logic [2:0] w_next_redirect_cnt;

    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic       w_load_use;

    // ------------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------------
    always_comb begin
        w_uses_rs1 = (if_id_opcode == c_op_rtype)  ||
                     (if_id_opcode == c_op_load)   ||
                     (if_id_opcode == c_op_store)  ||
                     (if_id_opcode == c_op_branch) ||
                     (if_id_opcode == c_op_itype);
        w_uses_rs2 = (if_id_opcode == c_op_rtype)  ||
                     (if_id_opcode == c_op_store)  ||
                     (if_id_opcode == c_op_branch);
        w_load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                     ((w_uses_rs1 && (id_ex_rd == if_id_rs1)) ||
                      (w_uses_rs2 && (id_ex_rd == if_id_rs2)));
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_st_run;
            r_redirect_cnt <= 3'd0;
        end else begin
            r_state        <= w_next_state;
            r_redirect_cnt <= w_next_redirect_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        pc_write            = 1'b1;
        if_id_write         = 1'b1;
        if_id_flush         = 1'b0;
        id_ex_bubble        = 1'b0;
        ex_mem_flush        = 1'b0;
        pipe_hold           = 1'b0;
        w_next_state        = r_state;
        w_next_redirect_cnt = r_redirect_cnt;

        case (r_state)
            c_st_flush: begin
                // IF/ID only ever holds wrong-path or NOP data here, so
                // load_use and branch_taken are both ignored.
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                end else begin
                    if (r_redirect_cnt <= 3'd1) begin
                        w_next_state        = c_st_run;
                        w_next_redirect_cnt = 3'd0;
                    end else begin
                        w_next_redirect_cnt = r_redirect_cnt - 3'd1;
                    end
                end
            end

            // RUN and FREEZE share one decode: once memory is ready, a
            // held branch or load-use hazard takes effect this same cycle.
            default: begin
                if (mem_busy) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    pipe_hold    = 1'b1;
                    w_next_state = c_st_freeze;
                end else if (branch_taken) begin
                    if_id_flush         = 1'b1;
                    id_ex_bubble        = 1'b1;
                    ex_mem_flush        = 1'b1;
                    w_next_state        = c_st_flush;
                    w_next_redirect_cnt = c_redirect_init;
                end else if (w_load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_next_state = c_st_run;
                end else begin
                    w_next_state = c_st_run;
                end
            end
        endcase

        // While reset is asserted the pipe sees plain run-mode controls,
        // regardless of inputs or the state being cleared.
        if (reset) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            ex_mem_flush = 1'b0;
            pipe_hold    = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic             w_stall_evt;
    logic             w_flush_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Same priority as the decode: busy blocks both, branch beats load_use
    assign w_stall_evt = (r_state != c_st_flush) && !mem_busy &&
                         !branch_taken && w_load_use;
    assign w_flush_evt = (r_state != c_st_flush) && !mem_busy && branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_controller
// Description : Self-checking bench for hazard_stall_controller, built with
//               REDIRECT_LAT = 2. Counter expectations follow the
//               HAZARD_PERF_CNT_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_controller;

    localparam int CNT_W = 16;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold}
    localparam logic [5:0] c_run   = 6'b110000;
    localparam logic [5:0] c_stall = 6'b000100;
    localparam logic [5:0] c_flush = 6'b111110;
    localparam logic [5:0] c_hold  = 6'b000001;

    localparam logic [6:0] c_op_r   = 7'b0110011;
    localparam logic [6:0] c_op_ld  = 7'b0000011;
    localparam logic [6:0] c_op_st  = 7'b0100011;
    localparam logic [6:0] c_op_br  = 7'b1100011;
    localparam logic [6:0] c_op_i   = 7'b0010011;
    localparam logic [6:0] c_op_lui = 7'b0110111;

    logic             clk;
    logic             reset;
    logic [6:0]       if_id_opcode;
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_memread;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_flush;
    logic             pipe_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_vec;
    int n_fail;

    hazard_stall_controller #(
        .REDIRECT_LAT (2),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .if_id_opcode  (if_id_opcode),
        .if_id_rs1     (if_id_rs1),
        .if_id_rs2     (if_id_rs2),
        .id_ex_rd      (id_ex_rd),
        .id_ex_memread (id_ex_memread),
        .branch_taken  (branch_taken),
        .mem_busy      (mem_busy),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_flush  (ex_mem_flush),
        .pipe_hold     (pipe_hold),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return CNT_W'(n);
`else
        return CNT_W'(n * 0);
`endif
    endfunction

    task automatic set_in(input logic [6:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic mr, input logic br, input logic busy);
        if_id_opcode  = op;
        if_id_rs1     = rs1;
        if_id_rs2     = rs2;
        id_ex_rd      = rd;
        id_ex_memread = mr;
        branch_taken  = br;
        mem_busy      = busy;
    endtask

    task automatic check_out(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ex_mem_flush, pipe_hold};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] act,
                             input logic [CNT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: count got %0d want %0d", name, act, exp);
        end
    endtask

    // Called just after a falling edge: pulses the async reset within the
    // low phase and leaves idle inputs applied.
    task automatic pulse_reset();
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);

        // Reset-asserted outputs stay at run values even with a hazard present
        #2;
        check_out("reset_outputs", c_run);
        check_cnt("reset_stall_cnt", stall_cnt, '0);
        check_cnt("reset_flush_cnt", flush_cnt, '0);
        @(negedge clk);

        //               name             op        rs1    rs2    rd     mr    br    busy  exp
        vecs[0]  = '{"idle",           7'd0,     5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, c_run};
        vecs[1]  = '{"ld_add_rs1",     c_op_r,   5'd5,  5'd2,  5'd5,  1'b1, 1'b0, 1'b0, c_stall};
        vecs[2]  = '{"ld_x0_use_x0",   c_op_r,   5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, c_run};
        vecs[3]  = '{"addi_rs1",       c_op_i,   5'd3,  5'd9,  5'd3,  1'b1, 1'b0, 1'b0, c_stall};
        vecs[4]  = '{"addi_rs2_only",  c_op_i,   5'd1,  5'd3,  5'd3,  1'b1, 1'b0, 1'b0, c_run};
        vecs[5]  = '{"sd_rs2",         c_op_st,  5'd1,  5'd9,  5'd9,  1'b1, 1'b0, 1'b0, c_stall};
        vecs[6]  = '{"lui_no_rs",      c_op_lui, 5'd4,  5'd4,  5'd4,  1'b1, 1'b0, 1'b0, c_run};
        vecs[7]  = '{"no_memread",     c_op_r,   5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, c_run};
        vecs[8]  = '{"branch",         7'd0,     5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, c_flush};
        vecs[9]  = '{"branch_and_lu",  c_op_r,   5'd5,  5'd2,  5'd5,  1'b1, 1'b1, 1'b0, c_flush};
        vecs[10] = '{"busy",           7'd0,     5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, c_hold};
        vecs[11] = '{"busy_all",       c_op_r,   5'd5,  5'd2,  5'd5,  1'b1, 1'b1, 1'b1, c_hold};
        vecs[12] = '{"beq_rs2",        c_op_br,  5'd7,  5'd8,  5'd8,  1'b1, 1'b0, 1'b0, c_stall};
        vecs[13] = '{"ld_rs1",         c_op_ld,  5'd6,  5'd6,  5'd6,  1'b1, 1'b0, 1'b0, c_stall};

        for (int i = 0; i < 14; i++) begin
            pulse_reset();
            set_in(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   vecs[i].mr, vecs[i].br, vecs[i].busy);
            #1;
            check_out(vecs[i].name, vecs[i].exp);
            @(negedge clk);
        end

        // Load-use: one stall cycle, then the load has advanced
        pulse_reset();
        set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 check_out("lu_seq_stall", c_stall);
        @(negedge clk);
        set_in(c_op_r, 5'd5, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check_out("lu_seq_release", c_run);
        check_cnt("lu_seq_stall_cnt", stall_cnt, exp_cnt(1));

        // Taken branch, busy in FLUSH freezes the redirect counter, then two
        // ignored load-use cycles before the hazard stalls again
        @(negedge clk);
        pulse_reset();
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1 check_out("br_seq_flush", c_flush);
        @(negedge clk);
        set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
        #1 check_out("br_seq_busy_hold", c_hold);
        @(negedge clk);
        set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
        #1 check_out("br_seq_ignore1", c_run);
        @(negedge clk);
        set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 check_out("br_seq_ignore2", c_run);
        @(negedge clk);
        #1 check_out("br_seq_run_stall", c_stall);
        check_cnt("br_seq_flush_cnt", flush_cnt, exp_cnt(1));
        check_cnt("br_seq_stall_cnt", stall_cnt, exp_cnt(0));

        // Branch and load-use together: flush only, no stall counted
        @(negedge clk);
        pulse_reset();
        set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
        #1 check_out("both_flush", c_flush);
        @(negedge clk);
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check_cnt("both_stall_cnt", stall_cnt, exp_cnt(0));
        check_cnt("both_flush_cnt", flush_cnt, exp_cnt(1));

        // mem_busy for 3 cycles over a load-use, stall on the 4th
        @(negedge clk);
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
            #1 check_out($sformatf("busy_lu_hold%0d", c), c_hold);
            @(negedge clk);
        end
        set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 check_out("busy_lu_stall", c_stall);
        @(negedge clk);
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check_out("busy_lu_after", c_run);
        check_cnt("busy_lu_stall_cnt", stall_cnt, exp_cnt(1));

        // Reset while in FLUSH with redirect counter = 2
        @(negedge clk);
        pulse_reset();
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1 check_out("rst_flush_enter", c_flush);
        @(negedge clk);
        set_in(c_op_r, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 check_out("rst_in_flush_ignore", c_run);
        check_cnt("rst_pre_flush_cnt", flush_cnt, exp_cnt(1));
        reset = 1'b1;
        #1 check_out("rst_asserted", c_run);
        check_cnt("rst_flush_cnt", flush_cnt, '0);
        reset = 1'b0;
        #1 check_out("rst_then_stall", c_stall);
        @(negedge clk);
        #1 check_cnt("rst_stall_cnt", stall_cnt, exp_cnt(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Hard stop in case stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: finished no want yes");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the ID-stage control decoder.
- Detects load-use hazards, squashes wrong-path instructions on taken branches and freezes the whole pipe while data memory is busy.
- Drives PC/IF-ID write enables, flush strobes and the ID/EX control-bubble select.
- A bubble zeroes the decoded control bundle: ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch all 0; ALUOp = 2'b00.

Parameters:
- REDIRECT_LAT, 1, cycles after a taken-branch flush during which IF/ID holds wrong-path data (range 1..7).
- CNT_W, 16, width of performance counters.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- if_id_opcode  input  7  opcode of instruction in IF/ID
- if_id_rs1  input  5  rs1 field in IF/ID
- if_id_rs2  input  5  rs2 field in IF/ID
- id_ex_rd  input  5  destination register in ID/EX
- id_ex_memread  input  1  MemRead of instruction in ID/EX
- branch_taken  input  1  Branch AND Zero, resolved in MEM stage
- mem_busy  input  1  data memory not ready; hold all stages
- pc_write  output  1  PC load enable
- if_id_write  output  1  IF/ID load enable
- if_id_flush  output  1  clear IF/ID to NOP
- id_ex_bubble  output  1  select zeroed control bundle into ID/EX
- ex_mem_flush  output  1  clear EX/MEM control bits
- pipe_hold  output  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt  output  CNT_W  load-use stall cycles (optional feature)
- flush_cnt  output  CNT_W  taken-branch flush events (optional feature)

Behaviour:
- State register: RUN, FLUSH, FREEZE. Reset: state = RUN, redirect counter = 0, counters = 0.
- Outputs are combinational from state and current inputs. Reset-asserted values: pc_write = 1, if_id_write = 1, all flush/bubble/hold = 0.
- rs1 is used by opcodes 0110011, 0000011, 0100011, 1100011, 0010011.
- rs2 is used by opcodes 0110011, 0100011, 1100011.
- load_use = id_ex_memread & (id_ex_rd != 0) & ((uses_rs1 & rd == rs1) | (uses_rs2 & rd == rs2)).
- Input priority each cycle: mem_busy > branch_taken > load_use.
- RUN:
  - mem_busy: pc_write = 0, if_id_write = 0, pipe_hold = 1, no flush. Next state FREEZE.
  - else branch_taken: if_id_flush = 1, id_ex_bubble = 1, ex_mem_flush = 1, pc_write = 1 (target loads). Load redirect counter = REDIRECT_LAT. Next state FLUSH.
  - else load_use: pc_write = 0, if_id_write = 0, id_ex_bubble = 1. Single-cycle stall; stays RUN. The load advances, so load_use clears next cycle.
  - else: all enables 1, no flush.
- FLUSH:
  - load_use is suppressed (IF/ID wrong-path/NOP).
  - Counter decrements each non-busy cycle; at 1 the next state is RUN.
  - mem_busy in FLUSH: hold as in FREEZE, counter frozen, state unchanged.
  - branch_taken in FLUSH cannot be legal (MEM holds a bubble). It is ignored.
- FREEZE:
  - Same outputs as RUN+mem_busy while mem_busy = 1.
  - On mem_busy = 0, outputs evaluate as RUN this cycle: a held branch_taken or load_use acts immediately. State follows RUN rules.
- Simultaneous branch_taken & load_use: flush wins; no stall counted.
- Reset mid-operation (any state): immediate return to RUN, counters cleared. No partial flush persists.

Optional Feature:
- HAZARD_PERF_CNT_EN
  - Defined: stall_cnt increments each cycle load_use causes a stall; flush_cnt increments on each accepted branch_taken. Both saturate at all-ones, neither increments while mem_busy.
  - Undefined: both outputs tied to 0; no counter flops.

Test Plan:
- ld x5,0(x1) in ID/EX, add x6,x5,x2 in IF/ID -> one cycle pc_write = 0, if_id_write = 0, id_ex_bubble = 1; next cycle all enables 1; stall_cnt = 1.
- Load to x0 followed by use of x0 -> no stall; addi x7,x3,4 after ld x3 with rs2 field = 3 only -> stall via rs1; sd rs2 = rd -> stall.
- branch_taken = 1 in RUN -> if_id_flush, id_ex_bubble, ex_mem_flush high one cycle. With REDIRECT_LAT = 2, load_use input ignored for 2 cycles, then RUN; flush_cnt = 1.
- branch_taken and load_use same cycle -> flush only, stall_cnt unchanged.
- mem_busy high 3 cycles during a load_use -> pipe_hold = 1, pc_write = 0 for 3 cycles; stall applied on the 4th cycle; stall_cnt = 1.
- Assert reset while in FLUSH with counter = 2 -> outputs return to run values immediately; counters 0; next load_use stalls normally.
